// File: rtl/multiply_tokens.sv
// Serial token multiplier: each '1' on a becomes FACTOR consecutive '1's on b,
// with owed copies queued into later '0' slots. Optional pend_cnt debug port: MULTIPLY_TOKENS_PEND_OUT_EN.
module multiply_tokens #(
  parameter int FACTOR  = 2,
  parameter int MAX_RUN = 200,
  localparam int RUN_W    = $clog2(MAX_RUN + 1),
  localparam int PEND_MAX = MAX_RUN * (FACTOR - 1),
  localparam int PEND_W   = (PEND_MAX > 0) ? $clog2(PEND_MAX + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  output logic              b,
  output logic              busy,
  output logic              overflow
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
  ,
  output logic [PEND_W-1:0] pend_cnt
`endif
);

  localparam logic [PEND_W:0]  PEND_INC = (PEND_W + 1)'(FACTOR - 1);
  localparam logic [PEND_W:0]  PEND_CAP = (PEND_W + 1)'(PEND_MAX);
  localparam logic [RUN_W-1:0] RUN_CAP  = RUN_W'(MAX_RUN);

  logic [RUN_W-1:0]  run_q, run_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [PEND_W:0]   pend_sum;

  function automatic logic [PEND_W-1:0] sat_pend(input logic [PEND_W:0] sum);
    return (sum > PEND_CAP) ? PEND_CAP[PEND_W-1:0] : sum[PEND_W-1:0];
  endfunction

  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] r);
    return (r == RUN_CAP) ? r : r + 1'b1;
  endfunction

  // One extra bit so the saturation compare sees the true sum
  assign pend_sum = {1'b0, pend_q} + PEND_INC;

  always_comb begin
    run_d  = run_q;
    pend_d = pend_q;
    b_d    = 1'b0;
    ovf_d  = ovf_q;
    if (a) begin
      b_d    = 1'b1;
      pend_d = sat_pend(pend_sum);
      run_d  = sat_run(run_q);
      ovf_d  = ovf_q | (run_q == RUN_CAP) | (pend_sum > PEND_CAP);
    end else begin
      run_d = '0;
      if (pend_q != '0) begin
        b_d    = 1'b1;
        pend_d = pend_q - 1'b1;
      end
    end
    busy_d = (pend_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      pend_q <= '0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign b        = b_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
  assign pend_cnt = pend_q;
`else
  // Owed count stays internal when the debug port is not built
`endif

endmodule

// File: tb/tb_multiply_tokens.sv
// Self-checking bench: four multiply_tokens instances with different FACTOR/MAX_RUN
// against a behavioural owed-token model.
module tb_multiply_tokens;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a_v = '0;
  logic [3:0] b_v, busy_v, ovf_v;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance configuration: 0:F2/M200  1:F3/M200  2:F2/M4  3:F1/M200
  int fac [4] = '{2, 3, 2, 1};
  int mrun[4] = '{200, 200, 4, 200};

  int run_m[4], pend_m[4], ovf_m[4], eb[4], ebusy[4], ones[4];

`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
  logic [7:0] pc0;
  logic [8:0] pc1;
  logic [2:0] pc2;
  logic [0:0] pc3;
  function automatic int pc_of(input int i);
    case (i)
      0: return int'(pc0);
      1: return int'(pc1);
      2: return int'(pc2);
      default: return int'(pc3);
    endcase
  endfunction
`endif

  multiply_tokens #(.FACTOR(2), .MAX_RUN(200)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .overflow(ovf_v[0])
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
    , .pend_cnt(pc0)
`endif
  );
  multiply_tokens #(.FACTOR(3), .MAX_RUN(200)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .overflow(ovf_v[1])
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
    , .pend_cnt(pc1)
`endif
  );
  multiply_tokens #(.FACTOR(2), .MAX_RUN(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .overflow(ovf_v[2])
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
    , .pend_cnt(pc2)
`endif
  );
  multiply_tokens #(.FACTOR(1), .MAX_RUN(200)) u3 (
    .clk(clk), .rst_n(rst_n), .a(a_v[3]), .b(b_v[3]), .busy(busy_v[3]), .overflow(ovf_v[3])
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
    , .pend_cnt(pc3)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      run_m[i] = 0; pend_m[i] = 0; ovf_m[i] = 0; eb[i] = 0; ebusy[i] = 0;
    end
  endtask

  // Owed tokens: every input '1' owes FACTOR-1 extra outputs, repaid one per '0' slot
  task automatic model_cycle(input int i, input bit av);
    int cap;
    cap = mrun[i] * (fac[i] - 1);
    if (av) begin
      eb[i] = 1;
      if (run_m[i] == mrun[i] || pend_m[i] + fac[i] - 1 > cap) ovf_m[i] = 1;
      pend_m[i] = (pend_m[i] + fac[i] - 1 > cap) ? cap : pend_m[i] + fac[i] - 1;
      run_m[i]  = (run_m[i] + 1 > mrun[i]) ? mrun[i] : run_m[i] + 1;
    end else begin
      run_m[i] = 0;
      eb[i] = (pend_m[i] > 0) ? 1 : 0;
      if (pend_m[i] > 0) pend_m[i] = pend_m[i] - 1;
    end
    ebusy[i] = (pend_m[i] != 0) ? 1 : 0;
  endtask

  task automatic step(input logic [3:0] av, input string tag);
    a_v = av;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      model_cycle(i, av[i]);
      ones[i] += int'(b_v[i]);
      checks++;
      if (int'(b_v[i]) !== eb[i] || int'(busy_v[i]) !== ebusy[i] || int'(ovf_v[i]) !== ovf_m[i]) begin
        failures++;
        if (failures < 30)
          $display("FAIL %s dut%0d b/busy/ovf: got %0b/%0b/%0b want %0d/%0d/%0d at %0t",
                   tag, i, b_v[i], busy_v[i], ovf_v[i], eb[i], ebusy[i], ovf_m[i], $time);
      end
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
      checks++;
      if (pc_of(i) !== pend_m[i]) begin
        failures++;
        $display("FAIL %s dut%0d pend_cnt: got %0d want %0d", tag, i, pc_of(i), pend_m[i]);
      end
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (b_v !== 4'b0 || busy_v !== 4'b0 || ovf_v !== 4'b0) begin
      failures++;
      $display("FAIL %s: b=%b busy=%b ovf=%b want all 0", tag, b_v, busy_v, ovf_v);
    end
`ifdef MULTIPLY_TOKENS_PEND_OUT_EN
    checks++;
    if (pc0 !== '0 || pc1 !== '0 || pc2 !== '0 || pc3 !== '0) begin
      failures++;
      $display("FAIL %s pend_cnt: got %0d %0d %0d %0d want 0", tag, pc0, pc1, pc2, pc3);
    end
`endif
  endtask

  task automatic test_reset();
    a_v = '0;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [5:0] seq;
    logic [5:0] bs;
    seq = 6'b100100;
    for (int k = 5; k >= 0; k--) begin
      step({3'b0, seq[k]}, "basic");
      bs[k] = b_v[0];
    end
    checks++;
    if (bs !== 6'b110110) begin
      failures++;
      $display("FAIL basic_seq: got %b want 110110", bs);
    end
  endtask

  task automatic test_factor3();
    logic [6:0] seq;
    logic [6:0] bs;
    seq = 7'b1100000;
    for (int k = 6; k >= 0; k--) begin
      step({2'b0, seq[k], 1'b0}, "factor3");
      bs[k] = b_v[1];
    end
    checks++;
    if (bs !== 7'b1111110) begin
      failures++;
      $display("FAIL factor3_seq: got %b want 1111110", bs);
    end
  endtask

  task automatic test_saturation();
    logic [8:0] seq;
    seq = 9'b111101111;
    ones[2] = 0;
    for (int k = 8; k >= 0; k--) step({1'b0, seq[k], 2'b0}, "sat");
    repeat (8) step(4'b0, "sat_drain");
    checks++;
    if (ones[2] !== 13 || ovf_v[2] !== 1'b1) begin
      failures++;
      $display("FAIL sat_count: got ones=%0d ovf=%0b want 13/1", ones[2], ovf_v[2]);
    end
  endtask

  task automatic test_long_run();
    ones[0] = 0;
    repeat (200) step(4'b0001, "run200");
    repeat (200) step(4'b0000, "run200_drain");
    checks++;
    if (ones[0] !== 400 || ovf_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL run200: got ones=%0d ovf=%0b want 400/0", ones[0], ovf_v[0]);
    end
    repeat (200) step(4'b0001, "run201");
    checks++;
    if (ovf_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL run201_pre: got ovf=%0b want 0", ovf_v[0]);
    end
    step(4'b0001, "run201");
    checks++;
    if (ovf_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL run201_rise: got ovf=%0b want 1", ovf_v[0]);
    end
    repeat (1000) step(4'b0000, "idle");
    checks++;
    if (ovf_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got ovf=%0b want 1", ovf_v[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) < 6);
      step(r, "random");
      checks++;
      if (busy_v[3] !== 1'b0 || b_v[3] !== r[3]) begin
        failures++;
        $display("FAIL f1_passthru: got b=%0b busy=%0b want b=%0b busy=0", b_v[3], busy_v[3], r[3]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    test_reset();
    repeat (3) step(4'b0001, "pre_drain");
    checks++;
    if (pend_m[0] !== 3 || busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_drain_setup: got busy=%0b want 1 (model pend %0d)", busy_v[0], pend_m[0]);
    end
    a_v = '0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ones[0] = 0;
    step(4'b0001, "post_reset");
    repeat (4) step(4'b0000, "post_reset");
    checks++;
    if (ones[0] !== 2) begin
      failures++;
      $display("FAIL post_reset_burst: got ones=%0d want 2", ones[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ones[i] = 0;
    test_reset();
    test_basic();
    test_factor3();
    test_saturation();
    test_long_run();
    test_random();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
